// File: rtl/satswarmv2_pkg.sv
// Shared types for the cae learned-clause consumer: literal, trail entry and backtrack FSM state.
package satswarmv2_pkg;
  localparam int TRAIL_LEVEL_W = 8;

  typedef logic signed [31:0] lit_t;

  typedef struct packed {
    lit_t                     lit;
    logic [TRAIL_LEVEL_W-1:0] level;
  } trail_entry_t;

  typedef enum logic [2:0] {S_IDLE, S_POP, S_ASSERT, S_DONE, S_UNSAT} bt_state_e;
endpackage

// File: rtl/cae_trail_mem.sv
// Assignment trail storage: one synchronous write port, combinational read of the top entry.
module cae_trail_mem
  import satswarmv2_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  trail_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output trail_entry_t  rdata
);
  trail_entry_t mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // An empty trail wraps raddr past DEPTH on non power-of-two depths.
  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/cae_backtrack.sv
// Learned-clause consumer: owns the trail, pops entries above the backtrack level, then implies the UIP.
// Define CAE_BT_STATS_EN to build the backtrack/pop statistics counters.
module cae_backtrack
  import satswarmv2_pkg::*;
#(
  parameter int MAX_LITS    = 8,
  parameter int LEVEL_W     = TRAIL_LEVEL_W,
  parameter int TRAIL_DEPTH = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_valid,
  output logic                             push_ready,
  input  lit_t                             push_lit,
  input  logic                             push_is_decision,
  input  logic                             learned_valid,
  input  logic [3:0]                       learned_len,
  input  lit_t [MAX_LITS-1:0]              learned_clause,
  input  logic [LEVEL_W-1:0]               backtrack_level,
  input  logic                             unsat,
  output logic [LEVEL_W-1:0]               decision_level,
  output logic [$clog2(TRAIL_DEPTH+1)-1:0] trail_len,
  output logic                             busy,
  output logic                             unassign_valid,
  output logic [31:0]                      unassign_var,
  output logic                             imply_valid,
  output lit_t                             imply_lit,
  output logic                             bt_done,
  output logic                             solver_unsat,
  output logic                             overflow,
  output logic [31:0]                      stat_backtracks,
  output logic [31:0]                      stat_pops
);
  localparam int LEN_W = $clog2(TRAIL_DEPTH+1);
  localparam int AW    = (TRAIL_DEPTH > 1) ? $clog2(TRAIL_DEPTH) : 1;

  bt_state_e          state, state_d;
  lit_t               uip_q;
  logic [LEVEL_W-1:0] bt_level_q, push_level;
  logic               unsat_pulse, full, pop_ok, push_fire, we, dl_max;
  trail_entry_t       wdata, top;

  logic unused_lits;
  assign unused_lits = &{1'b0, learned_clause[MAX_LITS-1:1]};

  cae_trail_mem #(.DEPTH(TRAIL_DEPTH), .AW(AW)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(AW'(trail_len)),
    .wdata(wdata),
    .raddr(AW'(trail_len - 1'b1)),
    .rdata(top)
  );

  assign full       = (trail_len == LEN_W'(TRAIL_DEPTH));
  assign pop_ok     = (trail_len != '0) && (LEVEL_W'(top.level) > bt_level_q);
  assign dl_max     = &decision_level;
  assign push_level = (push_is_decision && !dl_max) ? decision_level + 1'b1 : decision_level;
  assign push_fire  = push_valid && push_ready;
  assign unassign_var = top.lit[31] ? 32'(-top.lit) : 32'(top.lit);
  assign imply_lit  = uip_q;

  always_comb begin
    state_d        = state;
    busy           = 1'b0;
    unassign_valid = 1'b0;
    imply_valid    = 1'b0;
    bt_done        = 1'b0;
    we             = 1'b0;
    wdata          = '0;
    push_ready     = (state == S_IDLE) && !learned_valid && !full && !solver_unsat;
    case (state)
      S_IDLE:   if (learned_valid) state_d = (unsat || learned_len == '0) ? S_UNSAT : S_POP;
      S_POP: begin
        busy = 1'b1;
        if (pop_ok) unassign_valid = 1'b1;
        else        state_d = S_ASSERT;
      end
      S_ASSERT: begin
        busy    = 1'b1;
        state_d = S_DONE;
        if (!full) begin
          imply_valid = 1'b1;
          we          = 1'b1;
          wdata.lit   = uip_q;
          wdata.level = TRAIL_LEVEL_W'(bt_level_q);
        end
      end
      S_DONE: begin
        bt_done = 1'b1;
        state_d = S_IDLE;
      end
      S_UNSAT:  bt_done = unsat_pulse;
      default:  state_d = S_IDLE;
    endcase
    // Pushes only fire in IDLE, so they never collide with the ASSERT write.
    if (push_fire) begin
      we          = 1'b1;
      wdata.lit   = push_lit;
      wdata.level = TRAIL_LEVEL_W'(push_level);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      trail_len      <= '0;
      decision_level <= '0;
      bt_level_q     <= '0;
      uip_q          <= '0;
      solver_unsat   <= 1'b0;
      overflow       <= 1'b0;
      unsat_pulse    <= 1'b0;
    end else begin
      state       <= state_d;
      unsat_pulse <= 1'b0;
      if (state == S_IDLE && learned_valid) begin
        uip_q      <= learned_clause[0];
        bt_level_q <= backtrack_level;
        if (unsat || learned_len == '0) begin
          solver_unsat <= 1'b1;
          unsat_pulse  <= 1'b1;
        end
      end
      if (push_fire) begin
        decision_level <= push_level;
        trail_len      <= trail_len + 1'b1;
        if (push_is_decision && dl_max) overflow <= 1'b1;
      end
      if (unassign_valid) trail_len <= trail_len - 1'b1;
      if (state == S_POP && !pop_ok) decision_level <= bt_level_q;
      if (state == S_ASSERT) begin
        if (full) overflow  <= 1'b1;
        else      trail_len <= trail_len + 1'b1;
      end
    end
  end

`ifdef CAE_BT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_backtracks <= '0;
      stat_pops       <= '0;
    end else begin
      if (state == S_IDLE && learned_valid && !unsat && learned_len != '0)
        stat_backtracks <= stat_backtracks + 1'b1;
      if (unassign_valid) stat_pops <= stat_pops + 1'b1;
    end
  end
`else
  assign stat_backtracks = '0;
  assign stat_pops       = '0;
`endif
endmodule

// File: tb/tb_cae_backtrack.sv
// Bench for cae_backtrack: directed scenarios plus randomized push/backtrack rounds against a queue model.
module tb_cae_backtrack;
  import satswarmv2_pkg::*;
  localparam int DEPTH = 8;
`ifdef CAE_BT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0, reset = 1'b1;
  logic              push_valid, push_ready, push_is_decision, learned_valid, unsat;
  lit_t              push_lit, imply_lit;
  logic [3:0]        learned_len;
  lit_t [7:0]        learned_clause;
  logic [7:0]        backtrack_level, decision_level;
  logic [3:0]        trail_len;
  logic              busy, unassign_valid, imply_valid, bt_done, solver_unsat, overflow;
  logic [31:0]       unassign_var, stat_backtracks, stat_pops;

  cae_backtrack #(.MAX_LITS(8), .LEVEL_W(8), .TRAIL_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
    .push_lit(push_lit), .push_is_decision(push_is_decision), .learned_valid(learned_valid),
    .learned_len(learned_len), .learned_clause(learned_clause), .backtrack_level(backtrack_level),
    .unsat(unsat), .decision_level(decision_level), .trail_len(trail_len), .busy(busy),
    .unassign_valid(unassign_valid), .unassign_var(unassign_var), .imply_valid(imply_valid),
    .imply_lit(imply_lit), .bt_done(bt_done), .solver_unsat(solver_unsat), .overflow(overflow),
    .stat_backtracks(stat_backtracks), .stat_pops(stat_pops)
  );

  always #5 clk = ~clk;

  typedef struct { int lit; int level; } ent_t;
  ent_t q[$];
  int   m_dl, m_bts, m_pops;
  bit   m_ovf, m_unsat;
  int   checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset;
    q.delete();
    m_dl = 0; m_bts = 0; m_pops = 0; m_ovf = 0; m_unsat = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".trail_len"}, trail_len, q.size());
    chk({tag, ".decision_level"}, decision_level, m_dl);
    chk({tag, ".overflow"}, overflow, m_ovf);
    chk({tag, ".solver_unsat"}, solver_unsat, m_unsat);
    chk({tag, ".stat_backtracks"}, stat_backtracks, STATS ? m_bts : 0);
    chk({tag, ".stat_pops"}, stat_pops, STATS ? m_pops : 0);
  endtask

  task automatic do_push(input int lit, input bit dec);
    bit acc;
    push_valid = 1'b1; push_lit = lit; push_is_decision = dec;
    #1;
    acc = (q.size() < DEPTH) && !m_unsat;
    chk("push_ready", push_ready, acc);
    tick;
    push_valid = 1'b0; push_is_decision = 1'b0;
    if (acc) begin
      if (dec) begin
        if (m_dl == 255) m_ovf = 1'b1;
        else m_dl++;
      end
      q.push_back('{lit, m_dl});
    end
    chk("push.trail_len", trail_len, q.size());
    chk("push.decision_level", decision_level, m_dl);
  endtask

  // A push is offered alongside learned_valid and must lose.
  task automatic do_bt(input int uip, input int lvl);
    int   vars[$];
    int   k;
    bit   room;
    ent_t e;
    learned_valid = 1'b1; learned_len = 4'd2; unsat = 1'b0;
    learned_clause[0] = uip; backtrack_level = 8'(lvl);
    push_valid = 1'b1; push_lit = 999; push_is_decision = 1'b1;
    #1;
    chk("bt.push_ready_blocked", push_ready, 0);
    tick;
    learned_valid = 1'b0; push_valid = 1'b0; push_is_decision = 1'b0;
    while (q.size() > 0 && q[$].level > lvl) begin
      e = q.pop_back();
      vars.push_back(iabs(e.lit));
    end
    k = vars.size();
    room = q.size() < DEPTH;
    m_bts++; m_pops += k;
    for (int c = 1; c <= k + 3; c++) begin
      chk("bt.unassign_valid", unassign_valid, c <= k);
      if (c <= k) chk("bt.unassign_var", unassign_var, vars[c-1]);
      chk("bt.imply_valid", imply_valid, (c == k + 2) && room);
      if (c == k + 2 && room) chk("bt.imply_lit", imply_lit, uip);
      chk("bt.bt_done", bt_done, c == k + 3);
      if (c <= k + 1) chk("bt.busy", busy, 1);
      tick;
    end
    m_dl = lvl;
    if (room) q.push_back('{uip, lvl});
    else m_ovf = 1'b1;
    chk("bt.busy_after", busy, 0);
    chk_state("bt");
  endtask

  task automatic do_unsat(input bit via_len);
    learned_valid = 1'b1; unsat = !via_len; learned_len = via_len ? 4'd0 : 4'd3;
    learned_clause[0] = 7; backtrack_level = 8'd0;
    tick;
    learned_valid = 1'b0; unsat = 1'b0;
    m_unsat = 1'b1;
    chk("unsat.solver_unsat", solver_unsat, 1);
    chk("unsat.bt_done", bt_done, 1);
    chk("unsat.unassign_valid", unassign_valid, 0);
    push_valid = 1'b1; push_lit = 5;
    tick;
    chk("unsat.bt_done_once", bt_done, 0);
    chk("unsat.push_ready", push_ready, 0);
    chk("unsat.unassign_valid2", unassign_valid, 0);
    chk("unsat.imply_valid", imply_valid, 0);
    tick;
    push_valid = 1'b0;
    chk_state("unsat");
  endtask

  initial begin
    push_valid = 0; push_lit = 0; push_is_decision = 0; learned_valid = 0;
    learned_len = 0; learned_clause = '0; backtrack_level = 0; unsat = 0;
    model_reset();
    do_reset();
    chk_state("reset");
    chk("reset.busy", busy, 0);
    chk("reset.bt_done", bt_done, 0);
    chk("reset.push_ready", push_ready, 1);

    // Example trail: levels 1,1,2,2,3,3.
    do_push(10, 1); do_push(11, 0); do_push(12, 1);
    do_push(13, 0); do_push(-14, 1); do_push(15, 0);
    chk("t1.decision_level", decision_level, 3);
    chk("t1.trail_len", trail_len, 6);

    do_bt(-13, 1);
    chk("t2.trail_len", trail_len, 3);
    chk("t2.decision_level", decision_level, 1);

    // Backtrack to the current level: zero pops.
    do_push(20, 1); do_push(21, 1);
    do_bt(-22, 3);

    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++)
        do_push(($urandom_range(0, 1) ? -1 : 1) * int'($urandom_range(1, 1000)),
                $urandom_range(0, 2) == 0);
      do_bt(($urandom_range(0, 1) ? -1 : 1) * int'($urandom_range(1, 1000)),
            $urandom_range(0, m_dl));
    end

    // Full trail: 9th push refused, assert step overflows.
    do_reset();
    do_push(1, 1);
    for (int i = 2; i <= 8; i++) do_push(i, 0);
    chk("t5.push_ready_full", push_ready, 0);
    do_push(9, 0);
    do_bt(77, 1);
    chk("t5.overflow", overflow, 1);

    // Reset while popping.
    do_reset();
    do_push(31, 1); do_push(32, 1); do_push(33, 1);
    learned_valid = 1'b1; learned_len = 4'd2; learned_clause[0] = -31; backtrack_level = 8'd0;
    tick;
    learned_valid = 1'b0;
    chk("t6.unassign_in_pop", unassign_valid, 1);
    chk("t6.unassign_var", unassign_var, 33);
    reset = 1'b1;
    tick;
    model_reset();
    chk("t6.busy", busy, 0);
    chk("t6.unassign_valid", unassign_valid, 0);
    chk("t6.imply_valid", imply_valid, 0);
    chk("t6.bt_done", bt_done, 0);
    chk_state("t6");
    reset = 1'b0;
    tick;
    chk("t6.busy_after", busy, 0);

    do_push(40, 1);
    do_unsat(1'b0);
    do_reset();
    do_unsat(1'b1);
    do_reset();
    chk_state("final");
    chk("final.push_ready", push_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
